// File: rtl/capture_uart_tx.sv
// capture_uart_tx: drains the capture FIFO and streams each 32-bit word, MSB byte first, over 8N1 UART.
// Define CAPTURE_SYNC_HEADER_EN to prefix every word with the sync byte 0xA5 (5-byte frames).
`timescale 1ns/1ps
module capture_uart_tx #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic        i_clk,
    input  logic        _mrst,
    input  logic        i_fifo_empty,
    input  logic [31:0] i_fifo_data,
    output logic        o_fifo_read,
    output logic        o_tx,
    output logic        o_busy
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
`ifdef CAPTURE_SYNC_HEADER_EN
    localparam logic [2:0] IDX_LAST  = 3'd4;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
`else
    localparam logic [2:0] IDX_LAST  = 3'd3;
`endif

    typedef enum logic [2:0] {IDLE, READ, LATCH, START, DATA, STOP} state_t;

    state_t         state_reg;
    logic [CW-1:0]  baud_reg;
    logic [2:0]     bit_cnt_reg;
    logic [2:0]     byte_idx_reg;
    logic [31:0]    shift_reg;
    logic [7:0]     tx_byte_reg;

    always_ff @(posedge i_clk or negedge _mrst) begin
        if (!_mrst) begin
            state_reg    <= IDLE;
            baud_reg     <= '0;
            bit_cnt_reg  <= '0;
            byte_idx_reg <= '0;
            shift_reg    <= '0;
            tx_byte_reg  <= '0;
            o_fifo_read  <= 1'b0;
            o_tx         <= 1'b1;
            o_busy       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    o_tx     <= 1'b1;
                    baud_reg <= '0;
                    if (!i_fifo_empty) begin
                        state_reg   <= READ;
                        o_fifo_read <= 1'b1;
                        o_busy      <= 1'b1;
                    end
                end
                READ: begin
                    o_fifo_read <= 1'b0;
                    state_reg   <= LATCH;
                end
                LATCH: begin
                    // FIFO q is valid now, one cycle after the rdreq pulse.
                    byte_idx_reg <= '0;
                    baud_reg     <= '0;
                    o_tx         <= 1'b0;
                    state_reg    <= START;
`ifdef CAPTURE_SYNC_HEADER_EN
                    shift_reg    <= i_fifo_data;
                    tx_byte_reg  <= SYNC_BYTE;
`else
                    shift_reg    <= {i_fifo_data[23:0], 8'h00};
                    tx_byte_reg  <= i_fifo_data[31:24];
`endif
                end
                START: begin
                    if (baud_reg == BAUD_LAST) begin
                        baud_reg    <= '0;
                        bit_cnt_reg <= '0;
                        o_tx        <= tx_byte_reg[0];
                        state_reg   <= DATA;
                    end else begin
                        baud_reg <= baud_reg + CW'(1);
                    end
                end
                DATA: begin
                    if (baud_reg == BAUD_LAST) begin
                        baud_reg <= '0;
                        if (bit_cnt_reg == 3'd7) begin
                            o_tx      <= 1'b1;
                            state_reg <= STOP;
                        end else begin
                            // Bit 0 is already on the line; shift so bit[1] is the next one.
                            o_tx        <= tx_byte_reg[1];
                            tx_byte_reg <= {1'b0, tx_byte_reg[7:1]};
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        end
                    end else begin
                        baud_reg <= baud_reg + CW'(1);
                    end
                end
                STOP: begin
                    if (baud_reg == BAUD_LAST) begin
                        baud_reg <= '0;
                        if (byte_idx_reg < IDX_LAST) begin
                            byte_idx_reg <= byte_idx_reg + 3'd1;
                            tx_byte_reg  <= shift_reg[31:24];
                            shift_reg    <= {shift_reg[23:0], 8'h00};
                            o_tx         <= 1'b0;
                            state_reg    <= START;
                        end else begin
                            o_busy    <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end else begin
                        baud_reg <= baud_reg + CW'(1);
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    o_tx        <= 1'b1;
                    o_fifo_read <= 1'b0;
                    o_busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_capture_uart_tx.sv
// tb_capture_uart_tx: FIFO model + oversampling UART receiver checked against an expected byte stream.
`timescale 1ns/1ps
module tb_capture_uart_tx;
    localparam int CPB = 4;
`ifdef CAPTURE_SYNC_HEADER_EN
    localparam int FB = 5;
`else
    localparam int FB = 4;
`endif
    localparam int WORD_CYC    = FB * 10 * CPB;
    localparam int WORD_PERIOD = WORD_CYC + 3;

    logic        i_clk = 1'b0;
    logic        _mrst = 1'b0;
    logic        i_fifo_empty = 1'b1;
    logic [31:0] i_fifo_data = '0;
    logic        o_fifo_read;
    logic        o_tx;
    logic        o_busy;

    capture_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .i_clk        (i_clk),
        ._mrst        (_mrst),
        .i_fifo_empty (i_fifo_empty),
        .i_fifo_data  (i_fifo_data),
        .o_fifo_read  (o_fifo_read),
        .o_tx         (o_tx),
        .o_busy       (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          read_cnt = 0;
    int          busy_cnt = 0;
    logic        hold_empty = 1'b0;
    logic [31:0] fifo[$];
    logic [7:0]  exp_q[$];
    int          read_cyc[$];
    int          start_q[$];
    logic        bit0_q[$];
    logic        bit7_q[$];
    logic        rx_active = 1'b0;
    int          rx_n = 0;
    logic [39:0] rx_buf = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected wire bytes come straight from the word value: optional sync byte, then MSB byte first.
    task automatic push_word(input logic [31:0] w);
        fifo.push_back(w);
`ifdef CAPTURE_SYNC_HEADER_EN
        exp_q.push_back(8'hA5);
`endif
        for (int k = 3; k >= 0; k--) exp_q.push_back(8'((w >> (8 * k)) & 32'hFF));
        $display("push word %08h", w);
    endtask

    task automatic decode_frame();
        logic [7:0] b;
        logic       ok;
        logic [7:0] e;
        ok = (rx_buf[3:0] == 4'h0) && (rx_buf[39:36] == 4'hF);
        for (int i = 0; i < 8; i++) begin
            b[i] = rx_buf[4 + 4 * i];
            if (rx_buf[4 + 4 * i +: 4] != {4{b[i]}}) ok = 1'b0;
        end
        bit0_q.push_back(b[0]);
        bit7_q.push_back(b[7]);
        check("framing", 32'(ok), 1);
        if (exp_q.size() == 0) begin
            check("byte_expected", 0, 1);
        end else begin
            e = exp_q.pop_front();
            $display("rx byte %02h (model %02h) at cycle %0d", b, e, cyc);
            check("rx_byte", 32'(b), 32'(e));
        end
    endtask

    // FIFO model: non-show-ahead, q updates on the edge that sees rdreq, registered empty flag.
    always @(posedge i_clk) begin
        int n;
        cyc++;
        n = fifo.size();
        if (o_fifo_read) begin
            read_cnt++;
            read_cyc.push_back(cyc);
            if (n == 0) check("read_while_empty", 1, 0);
            else begin
                i_fifo_data <= fifo.pop_front();
                n--;
            end
        end
        i_fifo_empty <= (n == 0) || hold_empty;
    end

    // Line receiver: samples every cycle, a frame is 10 bits of CPB samples each.
    always @(negedge i_clk) begin
        if (o_busy) busy_cnt++;
        if (!_mrst) begin
            rx_active = 1'b0;
            rx_n = 0;
        end else if (!rx_active) begin
            if (!o_tx) begin
                rx_active = 1'b1;
                rx_buf = '0;
                rx_n = 1;
                start_q.push_back(cyc);
            end
        end else begin
            rx_buf[rx_n] = o_tx;
            rx_n++;
            if (rx_n == 10 * CPB) begin
                rx_active = 1'b0;
                decode_frame();
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n = 0;
        int quiet = 0;
        while (quiet < 4 && n < budget) begin
            @(negedge i_clk);
            n++;
            if (fifo.size() == 0 && i_fifo_empty && !o_busy && !rx_active) quiet++;
            else quiet = 0;
        end
        if (quiet < 4) check("idle_timeout", 1, 0);
    endtask

    task automatic wait_read(input int target, input int budget);
        int n = 0;
        while (read_cyc.size() < target && n < budget) begin
            @(negedge i_clk);
            n++;
        end
        if (read_cyc.size() < target) check("read_timeout", 1, 0);
    endtask

    initial begin
        int   r0;
        int   k;
        int   pushed;
        logic bad;

        // Reset state and a quiet empty FIFO.
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_tx", 32'(o_tx), 1);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_read", 32'(o_fifo_read), 0);
        @(negedge i_clk);
        _mrst = 1'b1;
        bad = 1'b0;
        repeat (100) begin
            @(negedge i_clk);
            if (o_fifo_read || !o_tx || o_busy) bad = 1'b1;
        end
        check("idle_quiet", 32'(bad), 0);

        // Single word.
        r0 = read_cnt;
        busy_cnt = 0;
        push_word(32'h12345678);
        wait_idle(2000);
        check("one_read", read_cnt - r0, 1);
        check("busy_cycles", busy_cnt, WORD_CYC + 2);
        check("bytes_left_1", exp_q.size(), 0);

        // Three queued words back to back.
        start_q.delete();
        push_word(32'hDEADBEEF);
        push_word(32'h00000000);
        push_word(32'hFFFFFFFF);
        wait_idle(4000);
        check("frames_3w", start_q.size(), 3 * FB);
        check("byte_spacing", start_q[1] - start_q[0], 10 * CPB);
        check("word_period_a", start_q[FB] - start_q[0], WORD_PERIOD);
        check("word_period_b", start_q[2 * FB] - start_q[FB], WORD_PERIOD);
        check("bytes_left_3", exp_q.size(), 0);

        // Empty flag toggling while a word is in flight.
        read_cyc.delete();
        push_word($urandom);
        wait_read(1, 20);
        push_word($urandom);
        repeat (100) begin
            @(negedge i_clk);
            hold_empty = 1'($urandom_range(0, 1));
        end
        hold_empty = 1'b0;
        wait_idle(2000);
        check("toggle_reads", read_cyc.size(), 2);
        check("toggle_gap", read_cyc[1] - read_cyc[0], WORD_PERIOD);
        check("bytes_left_t", exp_q.size(), 0);

        // Bit and byte ordering.
        bit0_q.delete();
        bit7_q.delete();
        push_word(32'h80000001);
        wait_idle(2000);
        check("first_data_bit", 32'(bit0_q[FB - 4]), 0);
        check("msb_of_0x80", 32'(bit7_q[FB - 4]), 1);
        check("last_data_bit", 32'(bit7_q[FB - 1]), 0);

        // Asynchronous reset in the middle of the data bits of byte 2.
        read_cyc.delete();
        push_word($urandom);
        wait_read(1, 20);
        repeat (95) @(posedge i_clk);
        #2;
        _mrst = 1'b0;
        #1;
        check("mid_rst_tx", 32'(o_tx), 1);
        check("mid_rst_busy", 32'(o_busy), 0);
        check("mid_rst_read", 32'(o_fifo_read), 0);
        exp_q.delete();
        repeat (3) @(negedge i_clk);
        _mrst = 1'b1;
        r0 = read_cnt;
        bad = 1'b0;
        repeat (60) begin
            @(negedge i_clk);
            if (!o_tx || o_busy || o_fifo_read) bad = 1'b1;
        end
        check("post_rst_quiet", 32'(bad), 0);
        check("post_rst_reads", read_cnt - r0, 0);

        // Randomized bursts.
        r0 = read_cnt;
        pushed = 0;
        for (int it = 0; it < 8; it++) begin
            repeat ($urandom_range(0, 120)) @(negedge i_clk);
            k = $urandom_range(1, 2);
            for (int j = 0; j < k; j++) push_word($urandom);
            pushed += k;
        end
        wait_idle(8000);
        check("rand_reads", read_cnt - r0, pushed);
        check("bytes_left_r", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
